// File: rtl/vm_pkg.sv
// Shared virtual-memory definitions: PTE layout, fault encodings, fault-handler
// FSM states and the PTE assembly helper.
package vm_pkg;

  localparam int PAGE_OFFSET_BITS = 12;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_PPN_LSB = 12;
  localparam int PTE_PPN_MSB = 31;

  typedef enum logic [1:0] {
    FT_NOT_PRESENT = 2'b00,
    FT_READ        = 2'b01,
    FT_WRITE       = 2'b10,
    FT_WRITE_ALT   = 2'b11
  } fault_type_t;

  typedef enum logic [2:0] {
    PF_IDLE,
    PF_ALLOC,
    PF_VICTIM,
    PF_EVICT,
    PF_LOAD,
    PF_RESPOND,
    PF_DRAIN
  } pf_state_t;

  // Freshly loaded pages are always valid and readable, never executable.
  function automatic logic [31:0] build_pte(input logic [19:0]  ppn,
                                            input fault_type_t  ft,
                                            input logic         user);
    logic [31:0] pte;
    pte                          = '0;
    pte[PTE_PPN_MSB:PTE_PPN_LSB] = ppn;
    pte[PTE_V]                   = 1'b1;
    pte[PTE_R]                   = 1'b1;
    pte[PTE_W]                   = (ft == FT_WRITE) || (ft == FT_WRITE_ALT);
    pte[PTE_X]                   = 1'b0;
    pte[PTE_U]                   = user;
    return pte;
  endfunction

endpackage

// File: rtl/page_fault_handler_if.sv
// Bundle between the page-fault handler (master) and its environment: the VM
// controller, frame allocator, replacement unit and backing store (slave).
interface page_fault_handler_if
  import vm_pkg::*;
#(
  parameter int VA_WIDTH   = 32,
  parameter int FRAME_BITS = 8
) ();

  logic                               page_fault;
  logic [VA_WIDTH-1:0]                fault_addr;
  logic [1:0]                         fault_type;
  logic                               user_page;
  logic                               fault_handled;
  logic [31:0]                        new_pte;
  logic                               alloc_req;
  logic                               alloc_valid;
  logic [FRAME_BITS-1:0]              alloc_frame;
  logic                               out_of_memory;
  logic                               victim_req;
  logic                               victim_valid;
  logic [FRAME_BITS-1:0]              victim_frame;
  logic                               bs_req;
  logic                               bs_write;
  logic [FRAME_BITS-1:0]              bs_frame;
  logic [VA_WIDTH-PAGE_OFFSET_BITS-1:0] bs_vpn;
  logic                               bs_ack;
  logic                               busy;
  logic [31:0]                        handled_count;
  logic [31:0]                        evict_count;

  modport master (
    input  page_fault, fault_addr, fault_type, user_page,
    input  alloc_valid, alloc_frame, out_of_memory,
    input  victim_valid, victim_frame, bs_ack,
    output fault_handled, new_pte, alloc_req, victim_req,
    output bs_req, bs_write, bs_frame, bs_vpn,
    output busy, handled_count, evict_count
  );

  modport slave (
    output page_fault, fault_addr, fault_type, user_page,
    output alloc_valid, alloc_frame, out_of_memory,
    output victim_valid, victim_frame, bs_ack,
    input  fault_handled, new_pte, alloc_req, victim_req,
    input  bs_req, bs_write, bs_frame, bs_vpn,
    input  busy, handled_count, evict_count
  );

endinterface

// File: rtl/page_fault_handler.sv
// Page-fault service FSM: obtains a frame (allocation or eviction), loads the
// page from backing store and returns the new PTE with a one-cycle pulse.
module page_fault_handler
  import vm_pkg::*;
#(
  parameter int VA_WIDTH   = 32,
  parameter int NUM_FRAMES = 256,
  parameter int FRAME_BITS = $clog2(NUM_FRAMES)
) (
  input logic                  clk,
  input logic                  rst_n,
  page_fault_handler_if.master bus
);

  localparam int VPN_BITS = VA_WIDTH - PAGE_OFFSET_BITS;

  pf_state_t             state_q, state_d;
  logic [VPN_BITS-1:0]   vpn_q;
  fault_type_t           type_q;
  logic                  user_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  abort_q;
  logic [31:0]           handled_q;
  logic [31:0]           evict_q;
  logic                  abort_now;
  logic                  in_window;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.fault_addr[PAGE_OFFSET_BITS-1:0];

  // The controller dropping page_fault anywhere from ALLOC to LOAD abandons the fault.
  assign in_window = (state_q == PF_ALLOC) || (state_q == PF_VICTIM) ||
                     (state_q == PF_EVICT) || (state_q == PF_LOAD);
  assign abort_now = abort_q || !bus.page_fault;

  // NOTE: combinational block assigns state_d first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PF_IDLE:    if (bus.page_fault) state_d = PF_ALLOC;
      PF_ALLOC: begin
        if (!bus.page_fault)        state_d = PF_DRAIN;
        else if (bus.alloc_valid)   state_d = PF_LOAD;
        else if (bus.out_of_memory) state_d = PF_VICTIM;
      end
      PF_VICTIM: begin
        if (!bus.page_fault)        state_d = PF_DRAIN;
        else if (bus.victim_valid)  state_d = PF_EVICT;
      end
      PF_EVICT:   if (bus.bs_ack) state_d = abort_now ? PF_DRAIN : PF_LOAD;
      PF_LOAD:    if (bus.bs_ack) state_d = abort_now ? PF_DRAIN : PF_RESPOND;
      PF_RESPOND: state_d = PF_DRAIN;
      PF_DRAIN:   if (!bus.page_fault) state_d = PF_IDLE;
      default:    state_d = PF_IDLE;
    endcase
  end

  // NOTE: every register, including the latched fault context, is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PF_IDLE;
      vpn_q     <= '0;
      type_q    <= FT_NOT_PRESENT;
      user_q    <= 1'b0;
      frame_q   <= '0;
      abort_q   <= 1'b0;
      handled_q <= '0;
      evict_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      unique case (state_q)
        PF_IDLE: if (bus.page_fault) begin
          vpn_q  <= bus.fault_addr[VA_WIDTH-1:PAGE_OFFSET_BITS];
          type_q <= fault_type_t'(bus.fault_type);
          user_q <= bus.user_page;
        end
        PF_ALLOC:   if (bus.alloc_valid) frame_q <= bus.alloc_frame;
        PF_VICTIM:  if (state_d == PF_EVICT) begin
          frame_q <= bus.victim_frame;
          evict_q <= evict_q + 32'd1;
        end
        PF_RESPOND: handled_q <= handled_q + 32'd1;
        default: ;
      endcase
      if (state_q == PF_IDLE)                abort_q <= 1'b0;
      else if (in_window && !bus.page_fault) abort_q <= 1'b1;
    end
  end

  assign bus.alloc_req     = (state_q == PF_ALLOC);
  assign bus.victim_req    = (state_q == PF_VICTIM);
  assign bus.bs_req        = (state_q == PF_EVICT) || (state_q == PF_LOAD);
  assign bus.bs_write      = (state_q == PF_EVICT);
  assign bus.bs_frame      = bus.bs_req ? frame_q : '0;
  assign bus.bs_vpn        = (state_q == PF_LOAD) ? vpn_q : '0;
  assign bus.fault_handled = (state_q == PF_RESPOND);
  assign bus.new_pte       = (state_q == PF_RESPOND) ? build_pte(20'(frame_q), type_q, user_q) : '0;
  assign bus.busy          = (state_q != PF_IDLE);
  assign bus.handled_count = handled_q;
  assign bus.evict_count   = evict_q;

endmodule
